posit_decode_pipe: RTL and testbench
====================================

POSIT_DECODE_PIPE -- requirements
Module: posit_decode_pipe

Interface
REQ-001 SHALL have parameter N, default 10: posit word width.
REQ-002 SHALL have parameter ES, default 4: exponent field width.
REQ-003 SHALL derive localparams FRAC_W = N-3-ES (default 3) and SCALE_W = ES+$clog2(N)+1 (default 9).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  in_posit holds a word.
REQ-007 SHALL have port in_ready  output  1  stage 1 accepts this cycle.
REQ-008 SHALL have port in_posit  input  N  raw posit word.
REQ-009 SHALL have port out_valid  output  1  decoded result present.
REQ-010 SHALL have port out_ready  input  1  downstream multiplier consumes this cycle.
REQ-011 SHALL have port out_sign  output  1  sign bit.
REQ-012 SHALL have port out_scale  output  SCALE_W  signed scale, k*2^ES + e.
REQ-013 SHALL have port out_mant  output  FRAC_W+1  mantissa with hidden one at MSB.
REQ-014 SHALL have ports out_pzero and out_pinf  output  1 each  zero and NaR flags.

Function
REQ-015 SHALL be a 2-stage elastic pipeline; transfer occurs when valid and ready are both high.
REQ-016 SHALL have stage 1 register sign, zero/NaR flags and magnitude (two's complement of in_posit when sign=1).
REQ-017 SHALL have stage 2 register regime run length, exponent and fraction extracted from the stage-1 magnitude.
REQ-018 SHALL use s2_ready = !s2_valid | out_ready and in_ready = !s1_valid | s2_ready (combinational; no bubble on full throughput).
REQ-019 SHALL give latency exactly 2 cycles from input transfer to out_valid with out_ready held high; throughput 1 word per cycle.
REQ-020 SHALL hold output fields stable while out_valid=1 and out_ready=0.
REQ-021 SHALL set regime k = run-1 for a run of ones and k = -run for a run of zeros, where the run starts below the sign bit and ends at the opposite bit or the LSB.
REQ-022 SHALL take ES exponent bits after the terminator; missing (truncated) bits read as 0.
REQ-023 SHALL left-align the remaining bits under the hidden one in out_mant and zero-fill to FRAC_W bits.
REQ-024 SHALL decode all-zero input as out_pzero=1, and 1 followed by zeros as out_pinf=1; in both cases out_sign=0, out_scale=0, out_mant=0.
REQ-025 SHALL preserve input order; no word lost or duplicated under any out_ready pattern.

Reset
REQ-026 SHALL clear both stage valids on reset; out_valid=0 in the cycle after reset is sampled high.
REQ-027 SHALL reset all output fields (sign, scale, mant, pzero, pinf) to 0.
REQ-028 SHALL discard in-flight words on reset mid-operation; in_ready=1 on the first cycle after reset deasserts.

Configuration
REQ-029 SHALL, with macro POSIT_DECODE_STATS_EN defined, add output ports zero_cnt[15:0] and nar_cnt[15:0]; each increments on an output transfer flagged pzero or pinf respectively, saturates at 16'hFFFF, and clears on reset.
REQ-030 SHALL, without POSIT_DECODE_STATS_EN, omit those ports and counters entirely, with no other behavioural change.

Verification
REQ-031 SHALL cover: in_posit=10'h100, out_ready=1 -> 2 cycles later sign=0, scale=0, mant=4'b1000.
REQ-032 SHALL cover: 10'h180 -> scale=16, mant=4'b1000; 10'h300 -> sign=1, scale=0, mant=4'b1000.
REQ-033 SHALL cover: 10'h001 -> scale=9'h180 (-128); 10'h1FF -> scale=128; 10'h000 -> pzero=1; 10'h200 -> pinf=1.
REQ-034 SHALL cover: 4 back-to-back words with out_ready=0 for 3 cycles -> in_ready drops after 2 words are held, outputs stable, all 4 emerge in order.
REQ-035 SHALL cover: reset pulsed with 2 words in flight -> out_valid=0 the next cycle, no stale word emitted, and (with POSIT_DECODE_STATS_EN) counters=0.

Source files
------------

// File: rtl/posit_decode_pipe.sv
// posit_decode_pipe: 2-stage elastic posit decoder (sign/magnitude, then regime/exponent/fraction).
// Define POSIT_DECODE_STATS_EN to add saturating zero_cnt/nar_cnt output-transfer counters.
module posit_decode_pipe #(
    parameter int N  = 10,
    parameter int ES = 4,
    localparam int FRAC_W  = N - 3 - ES,
    localparam int SCALE_W = ES + $clog2(N) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_posit,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sign,
    output logic [SCALE_W-1:0] out_scale,
    output logic [FRAC_W:0]    out_mant,
    output logic               out_pzero,
    output logic               out_pinf
`ifdef POSIT_DECODE_STATS_EN
    ,
    output logic [15:0]        zero_cnt,
    output logic [15:0]        nar_cnt
`endif
);
    localparam int RW = $clog2(N) + 1;

    logic                 s1_valid, s1_sign, s1_zero, s1_nar;
    logic [N-2:0]         s1_mag;
    logic [N-4:0]         rem;
    logic [RW-1:0]        run;
    logic                 done;
    logic [SCALE_W-1:0]   k;
    logic                 s2_ready, special;

    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;
    assign special  = s1_zero || s1_nar;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_nar   <= 1'b0;
            s1_mag   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= in_posit[N-1];
                s1_zero <= in_posit == '0;
                s1_nar  <= in_posit == {1'b1, {(N-1){1'b0}}};
                s1_mag  <= in_posit[N-1] ? -in_posit[N-2:0] : in_posit[N-2:0];
            end
        end
    end

    // Bits after the regime terminator, exponent on top and fraction below, zero-filled on truncation.
    always_comb begin
        run  = '0;
        done = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            done = done || (s1_mag[i] != s1_mag[N-2]);
            run  = done ? run : run + RW'(1);
        end
        rem = (N-3)'((s1_mag << (run + RW'(1))) >> 2);
        k   = s1_mag[N-2] ? SCALE_W'(run) - SCALE_W'(1) : -SCALE_W'(run);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_scale <= '0;
            out_mant  <= '0;
            out_pzero <= 1'b0;
            out_pinf  <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sign  <= s1_sign && !special;
                out_scale <= special ? '0 : (k << ES) | SCALE_W'(rem[N-4 -: ES]);
                out_mant  <= special ? '0 : {1'b1, rem[FRAC_W-1:0]};
                out_pzero <= s1_zero;
                out_pinf  <= s1_nar;
            end
        end
    end

`ifdef POSIT_DECODE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            zero_cnt <= '0;
            nar_cnt  <= '0;
        end else if (out_valid && out_ready) begin
            zero_cnt <= (out_pzero && zero_cnt != 16'hFFFF) ? zero_cnt + 16'd1 : zero_cnt;
            nar_cnt  <= (out_pinf && nar_cnt != 16'hFFFF) ? nar_cnt + 16'd1 : nar_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_posit_decode_pipe.sv
// tb_posit_decode_pipe: scoreboard bench for posit_decode_pipe (N=10, ES=4) with a value-level decode model.
module tb_posit_decode_pipe;
    typedef struct packed {
        logic       sign;
        logic [8:0] scale;
        logic [3:0] mant;
        logic       pzero;
        logic       pinf;
    } exp_t;

    logic       clk = 0, reset = 1, in_valid = 0, out_ready = 0;
    logic [9:0] in_posit = '0;
    logic       in_ready, out_valid, out_sign, out_pzero, out_pinf;
    logic [8:0] out_scale;
    logic [3:0] out_mant;
    exp_t       in_exp = '0;
    exp_t       q[$];
    int         errors = 0, checks = 0;
    bit         rand_rdy = 0;
`ifdef POSIT_DECODE_STATS_EN
    logic [15:0] zero_cnt, nar_cnt;
    int          m_zero = 0, m_nar = 0;
`endif

    always #5 clk = ~clk;

    posit_decode_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_posit(in_posit),
        .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign), .out_scale(out_scale),
        .out_mant(out_mant), .out_pzero(out_pzero), .out_pinf(out_pinf)
`ifdef POSIT_DECODE_STATS_EN
        , .zero_cnt(zero_cnt), .nar_cnt(nar_cnt)
`endif
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endfunction

    function automatic exp_t mk(logic s, logic [8:0] sc, logic [3:0] m, logic z, logic n);
        return {s, sc, m, z, n};
    endfunction

    // Value-level decode: walk the magnitude bit by bit, reading past the LSB as zero.
    function automatic exp_t model(logic [9:0] p);
        exp_t e = '0;
        int v, i, run, r0, k, ex, fr;
        if (p == 10'h000) begin e.pzero = 1; return e; end
        if (p == 10'h200) begin e.pinf = 1; return e; end
        e.sign = p[9];
        v = p[9] ? 1024 - int'(p) : int'(p);
        r0 = (v >> 8) & 1;
        i = 8;
        run = 0;
        while (i >= 0 && ((v >> i) & 1) == r0) begin run++; i--; end
        k = r0 ? run - 1 : -run;
        i--;
        ex = 0;
        for (int j = 0; j < 4; j++) begin ex = ex * 2 + (i >= 0 ? (v >> i) & 1 : 0); i--; end
        fr = 0;
        for (int j = 0; j < 3; j++) begin fr = fr * 2 + (i >= 0 ? (v >> i) & 1 : 0); i--; end
        e.scale = 9'(k * 16 + ex);
        e.mant = 4'(8 + fr);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h required none", {out_sign, out_scale, out_mant, out_pzero, out_pinf});
                end else begin
                    chk("out_fields", {out_sign, out_scale, out_mant, out_pzero, out_pinf}, q[0]);
                    if (out_ready) begin
`ifdef POSIT_DECODE_STATS_EN
                        if (q[0].pzero) m_zero++;
                        if (q[0].pinf) m_nar++;
`endif
                        void'(q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(in_exp);
        end
    end

    always @(posedge clk) if (rand_rdy) begin #1; out_ready = ($urandom_range(0, 3) != 0); end

    task automatic send(input logic [9:0] p, input exp_t e);
        bit ok;
        int n = 0;
        in_valid = 1;
        in_posit = p;
        in_exp = e;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 required 1 within 200 cycles");
        end
        in_valid = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] p;
        int sel, n;
        repeat (3) cyc();
        reset = 0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_fields", {out_sign, out_scale, out_mant, out_pzero, out_pinf}, 0);
`ifdef POSIT_DECODE_STATS_EN
        chk("reset_zero_cnt", zero_cnt, 0);
        chk("reset_nar_cnt", nar_cnt, 0);
`endif
        cyc();

        out_ready = 1;
        in_valid = 1;
        in_posit = 10'h100;
        in_exp = mk(0, 9'd0, 4'b1000, 0, 0);
        cyc();
        in_valid = 0;
        @(negedge clk);
        chk("latency_cycle1", out_valid, 0);
        cyc();
        @(negedge clk);
        chk("latency_cycle2", out_valid, 1);
        cyc();

        send(10'h180, mk(0, 9'd16, 4'b1000, 0, 0));
        send(10'h300, mk(1, 9'd0, 4'b1000, 0, 0));
        send(10'h001, mk(0, 9'h180, 4'b1000, 0, 0));
        send(10'h1FF, mk(0, 9'd128, 4'b1000, 0, 0));
        send(10'h000, mk(0, 9'd0, 4'b0000, 1, 0));
        send(10'h200, mk(0, 9'd0, 4'b0000, 0, 1));
        send(10'h3FF, mk(1, 9'h180, 4'b1000, 0, 0));
        send(10'h0FF, mk(0, 9'h1FF, 4'b1111, 0, 0));
        repeat (3) cyc();

        out_ready = 0;
        send(10'h140, model(10'h140));
        send(10'h2A5, model(10'h2A5));
        in_valid = 1;
        in_posit = 10'h07C;
        in_exp = model(10'h07C);
        @(negedge clk);
        chk("stall_in_ready_a", in_ready, 0);
        cyc();
        @(negedge clk);
        chk("stall_in_ready_b", in_ready, 0);
        cyc();
        out_ready = 1;
        send(10'h07C, model(10'h07C));
        send(10'h3C1, model(10'h3C1));
        repeat (4) cyc();
        chk("stall_drained", q.size(), 0);

        out_ready = 0;
        send(10'h000, model(10'h000));
        send(10'h200, model(10'h200));
        reset = 1;
        q.delete();
`ifdef POSIT_DECODE_STATS_EN
        m_zero = 0;
        m_nar = 0;
`endif
        cyc();
        reset = 0;
        @(negedge clk);
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_in_ready", in_ready, 1);
`ifdef POSIT_DECODE_STATS_EN
        chk("midreset_zero_cnt", zero_cnt, 0);
        chk("midreset_nar_cnt", nar_cnt, 0);
`endif
        cyc();
        out_ready = 1;
        repeat (4) cyc();

        rand_rdy = 1;
        for (int t = 0; t < 1500; t++) begin
            if ($urandom_range(0, 3) == 0) cyc();
            else begin
                sel = $urandom_range(0, 9);
                p = sel == 0 ? 10'h000 : sel == 1 ? 10'h200 : 10'($urandom);
                send(p, model(p));
            end
        end
        rand_rdy = 0;
        cyc();
        out_ready = 1;
        n = 0;
        while (q.size() > 0 && n < 100) begin cyc(); n++; end
        chk("final_drain", q.size(), 0);
`ifdef POSIT_DECODE_STATS_EN
        @(negedge clk);
        chk("final_zero_cnt", zero_cnt, 32'(m_zero));
        chk("final_nar_cnt", nar_cnt, 32'(m_nar));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
